// File: rtl/poly_wave_gen.sv
`default_nettype none
// poly_wave_gen: time-multiplexed oscillator bank with saw/square/triangle/pulse/noise voices
// and per-channel hard sync. Rev 1.0

module poly_wave_gen #(
  parameter int WAVE_DEPTH  = 8,
  parameter int PHASE_DEPTH = 16,
  parameter int CHANNELS    = 4,
  parameter int CH_BITS     = 2
) (
  input  logic                            Clock,
  input  logic                            Reset,
  input  logic                            Tick,
  input  logic [CHANNELS*PHASE_DEPTH-1:0] Incr,
  input  logic [CHANNELS*3-1:0]           WaveType,
  input  logic [CHANNELS*WAVE_DEPTH-1:0]  Duty,
  input  logic [CHANNELS-1:0]             Sync,
  output logic [WAVE_DEPTH-1:0]           Waveform,
  output logic [CH_BITS-1:0]              Channel,
  output logic                            Valid,
  output logic                            Overrun
);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [15:0]         LFSR_SEED = 16'hACE1;
  localparam logic [WAVE_DEPTH-1:0] WAVE_MAX = '1;

  state_t                 state, next_state;
  logic [CH_BITS-1:0]     idx;
  logic [CHANNELS-1:0]    sync_q;
  logic [PHASE_DEPTH-1:0] phase [CHANNELS];
  logic [15:0]            lfsr;

  logic                   last;
  logic [PHASE_DEPTH-1:0] cur_phase;
  logic [PHASE_DEPTH-1:0] cur_incr;
  logic [2:0]             cur_mode;
  logic [WAVE_DEPTH-1:0]  cur_duty;
  logic [WAVE_DEPTH-1:0]  p;
  logic [WAVE_DEPTH-1:0]  tri_w;
  logic [WAVE_DEPTH-1:0]  sample;
  logic                   lfsr_fb;

  assign last    = (idx == CH_BITS'(CHANNELS - 1));
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (Tick) next_state = SCAN;
      SCAN:    if (last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shared datapath: operands of the channel currently being scanned.
  always_comb begin
    cur_phase = phase[idx];
    cur_incr  = Incr[idx*PHASE_DEPTH +: PHASE_DEPTH];
    cur_mode  = WaveType[idx*3 +: 3];
    cur_duty  = Duty[idx*WAVE_DEPTH +: WAVE_DEPTH];
    p         = cur_phase[PHASE_DEPTH-1 -: WAVE_DEPTH];
    tri_w     = {p[WAVE_DEPTH-2:0], 1'b0};
    sample    = '0;
    case (cur_mode)
      3'd0:    sample = p;
      3'd1:    sample = p[WAVE_DEPTH-1] ? WAVE_MAX : '0;
      3'd2:    sample = p[WAVE_DEPTH-1] ? ~tri_w : tri_w;
      3'd3:    sample = (p < cur_duty) ? WAVE_MAX : '0;
      3'd4:    sample = lfsr[WAVE_DEPTH-1:0];
      default: sample = '0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx      <= '0;
      sync_q   <= '0;
      lfsr     <= LFSR_SEED;
      Waveform <= '0;
      Channel  <= '0;
      Valid    <= 1'b0;
      Overrun  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        phase[k] <= '0;
      end
    end else begin
      Valid   <= (state == SCAN);
      Overrun <= Tick && (state == SCAN);
      if (state == IDLE) begin
        if (Tick) begin
          sync_q <= Sync;
          idx    <= '0;
        end
      end else begin
        Waveform   <= sample;
        Channel    <= idx;
        phase[idx] <= sync_q[idx] ? '0 : cur_phase + cur_incr;
        lfsr       <= {lfsr[14:0], lfsr_fb};
        idx        <= last ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_poly_wave_gen.sv
`default_nettype none
// tb_poly_wave_gen: directed + randomized scans of poly_wave_gen against an arithmetic voice model.

module tb_poly_wave_gen;
  localparam int W  = 8;
  localparam int P  = 16;
  localparam int N  = 4;
  localparam int CB = 2;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Tick  = 1'b0;
  logic [N*P-1:0] Incr     = '0;
  logic [N*3-1:0] WaveType = '0;
  logic [N*W-1:0] Duty     = '0;
  logic [N-1:0]   Sync     = '0;
  logic [W-1:0]   Waveform;
  logic [CB-1:0]  Channel;
  logic           Valid;
  logic           Overrun;

  int total = 0;
  int bad   = 0;
  int m_ph [N];
  int m_exp[N];
  int m_lfsr;

  always #5 Clock = ~Clock;

  poly_wave_gen #(.WAVE_DEPTH(W), .PHASE_DEPTH(P), .CHANNELS(N), .CH_BITS(CB)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Incr(Incr), .WaveType(WaveType),
    .Duty(Duty), .Sync(Sync), .Waveform(Waveform), .Channel(Channel),
    .Valid(Valid), .Overrun(Overrun)
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_sample(input int ph, input int mode, input int duty, input int l);
    int pv, mx, half;
    pv   = ph >> (P - W);
    mx   = (1 << W) - 1;
    half = 1 << (W - 1);
    case (mode)
      0: return pv;
      1: return (pv >= half) ? mx : 0;
      2: return (pv < half) ? 2 * pv : mx - 2 * (pv - half);
      3: return (pv < duty) ? mx : 0;
      4: return l & mx;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_ph[k] = 0;
    m_lfsr = 'hACE1;
  endtask

  // One complete tick: model the scan, drive Tick, then check the emitted stream cycle by cycle.
  task automatic do_tick(input int gap, input bit dbl, input bit rst_mid);
    int incr, mode, duty, fb;
    for (int k = 0; k < N; k++) begin
      incr     = int'(Incr[k*P +: P]);
      mode     = int'(WaveType[k*3 +: 3]);
      duty     = int'(Duty[k*W +: W]);
      m_exp[k] = model_sample(m_ph[k], mode, duty, m_lfsr);
      m_ph[k]  = Sync[k] ? 0 : (m_ph[k] + incr) % (1 << P);
      fb       = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr   = ((m_lfsr << 1) | fb) & 'hFFFF;
    end
    Tick = 1'b1;
    step();
    Tick = dbl;
    Sync = '0;
    chk("valid_c1", 32'(Valid), 0);
    chk("overrun_c1", 32'(Overrun), 0);
    step();
    Tick = 1'b0;
    chk("overrun_c2", 32'(Overrun), 32'(dbl));
    chk("valid_ch0", 32'(Valid), 1);
    chk("channel_ch0", 32'(Channel), 0);
    chk("wave_ch0", 32'(Waveform), 32'(m_exp[0]));
    if (rst_mid) begin
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      model_reset();
      for (int i = 0; i < N; i++) begin
        chk("valid_after_reset", 32'(Valid), 0);
        step();
      end
      return;
    end
    for (int k = 1; k < N; k++) begin
      step();
      chk("valid_chk", 32'(Valid), 1);
      chk("channel_chk", 32'(Channel), 32'(k));
      chk("wave_chk", 32'(Waveform), 32'(m_exp[k]));
      chk("overrun_quiet", 32'(Overrun), 0);
    end
    step();
    chk("valid_end", 32'(Valid), 0);
    repeat (gap) step();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) step();
    chk("reset_wave", 32'(Waveform), 0);
    chk("reset_channel", 32'(Channel), 0);
    chk("reset_valid", 32'(Valid), 0);
    chk("reset_overrun", 32'(Overrun), 0);
    Reset = 1'b0;
    model_reset();
    step();

    // Saw on ch0, ticks spaced 8 cycles
    Incr[0 +: P] = 16'h1000;
    repeat (17) do_tick(2, 1'b0, 1'b0);

    // Square on ch1, triangle on ch2
    do_reset();
    Incr = '0;
    WaveType[3 +: 3] = 3'd1;
    WaveType[6 +: 3] = 3'd2;
    Incr[P +: P]     = 16'h2000;
    Incr[2*P +: P]   = 16'h2000;
    repeat (9) do_tick(0, 1'b0, 1'b0);

    // Pulse on ch3, then zero duty
    WaveType[9 +: 3] = 3'd3;
    Duty[3*W +: W]   = 8'h40;
    Incr[3*P +: P]   = 16'h4000;
    repeat (5) do_tick(1, 1'b0, 1'b0);
    Duty[3*W +: W]   = 8'h00;
    repeat (4) do_tick(1, 1'b0, 1'b0);

    // Dropped tick, then reset mid-scan, then all-saw scan from zero phase
    do_tick(1, 1'b1, 1'b0);
    do_tick(1, 1'b0, 1'b1);
    WaveType = '0;
    do_tick(1, 1'b0, 1'b0);

    // Noise on ch0, hard sync on ch1 at the fourth tick
    do_reset();
    Incr = '0;
    WaveType = '0;
    WaveType[0 +: 3] = 3'd4;
    Incr[P +: P]     = 16'h1000;
    for (int t = 1; t <= 5; t++) begin
      Sync[1] = (t == 4);
      do_tick(0, 1'b0, 1'b0);
    end

    // Randomized voices, modes, duties and sync requests
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++) begin
        Incr[k*P +: P]     = P'($urandom);
        WaveType[k*3 +: 3] = 3'($urandom_range(0, 7));
        Duty[k*W +: W]     = W'($urandom);
        Sync[k]            = ($urandom_range(0, 7) == 0);
      end
      do_tick($urandom_range(0, 3), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
